// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter.
// Requester indices, lock state encoding and the request bundle.
package mem_pkg;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int REQ_CPU = 0;
    localparam int REQ_DBG = 1;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_t;

    typedef struct packed {
        logic              write;
        logic              lock;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// Request/response and RAM-port bundle between requesters, arbiter and RAM.
// The arbiter is the slave; the requester/RAM side is the master.
interface ram_arbiter_if #(
    parameter int DataWidth = mem_pkg::DATA_W,
    parameter int AddrWidth = mem_pkg::ADDR_W
);
    logic [1:0]                reqValid;
    logic [1:0]                reqWrite;
    logic [1:0]                reqLock;
    logic [1:0][AddrWidth-1:0] reqAddr;
    logic [1:0][DataWidth-1:0] reqWData;
    logic [1:0]                reqReady;
    logic [1:0]                rspValid;
    logic [DataWidth-1:0]      rspData;
    logic                      ramWriteEnable;
    logic [AddrWidth-1:0]      ramWriteAddr;
    logic [DataWidth-1:0]      ramWriteData;
    logic [AddrWidth-1:0]      ramReadAddr;
    logic [DataWidth-1:0]      ramReadData;
    logic                      locked;

    modport slave (
        input  reqValid, reqWrite, reqLock, reqAddr, reqWData, ramReadData,
        output reqReady, rspValid, rspData, ramWriteEnable, ramWriteAddr,
        output ramWriteData, ramReadAddr, locked
    );

    modport master (
        output reqValid, reqWrite, reqLock, reqAddr, reqWData, ramReadData,
        input  reqReady, rspValid, rspData, ramWriteEnable, ramWriteAddr,
        input  ramWriteData, ramReadAddr, locked
    );
endinterface

// File: rtl/ram_arbiter_rr_picker2.sv
// Two-way round-robin picker: on a tie, grant the side that did not win last.
module rr_picker2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);
    always_comb begin
        grant = valid;
        if (&valid) grant = last ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU and the debug port,
// with round-robin arbitration, burst lock and tagged read return.
module ram_arbiter
    import mem_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);
    mem_req_t    req [2];
    mem_req_t    winReq;
    lock_state_t state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        pendValid_q, pendValid_d;
    logic        pendTag_q, pendTag_d;
    logic [1:0]  pick;
    logic [1:0]  grant;
    logic        win;
    logic        accepted;
    logic        doWrite;
    logic        doRead;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            req[i] = {bus.reqWrite[i], bus.reqLock[i],
                      bus.reqAddr[i], bus.reqWData[i]};
        end
    end

    rr_picker2 u_pick (
        .valid (bus.reqValid),
        .last  (last_q),
        .grant (pick)
    );

    // While locked only the owner may win; nothing is granted during reset.
    always_comb begin
        grant = '0;
        if (!rst) begin
            if (state_q == LOCKED) grant[owner_q] = bus.reqValid[owner_q];
            else                   grant = pick;
        end
    end

    assign win      = grant[REQ_DBG];
    assign accepted = |grant;
    assign winReq   = req[win];
    assign doWrite  = accepted && winReq.write;
    assign doRead   = accepted && !winReq.write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= UNLOCKED;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            pendValid_q <= 1'b0;
            pendTag_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            pendValid_q <= pendValid_d;
            pendTag_q   <= pendTag_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = accepted ? win : last_q;
        pendValid_d = doRead;
        pendTag_d   = win;
        case (state_q)
            UNLOCKED: begin
                if (accepted && winReq.lock) begin
                    state_d = LOCKED;
                    owner_d = win;
                end
            end
            LOCKED: begin
                if (!bus.reqValid[owner_q] || (accepted && !winReq.lock))
                    state_d = UNLOCKED;
            end
        endcase
    end

    always_comb begin
        bus.reqReady          = grant;
        bus.ramWriteEnable    = doWrite;
        bus.ramWriteAddr      = doWrite ? winReq.addr : '0;
        bus.ramWriteData      = doWrite ? winReq.wdata : '0;
        bus.ramReadAddr       = doRead ? winReq.addr : '0;
        bus.locked            = (state_q == LOCKED) && bus.reqValid[owner_q];
        bus.rspValid          = '0;
        bus.rspValid[REQ_CPU] = pendValid_q && (pendTag_q == 1'(REQ_CPU));
        bus.rspValid[REQ_DBG] = pendValid_q && (pendTag_q == 1'(REQ_DBG));
        bus.rspData           = pendValid_q ? bus.ramReadData : '0;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed plus random bench for ram_arbiter against a transaction-level
// model of grants, lock ownership, RAM contents and read returns.
module tb_ram_arbiter;
    logic        clk;
    logic        rst;
    logic [1:0]  rv, rw, rl;
    logic [15:0] ra [2];
    logic [15:0] rd [2];
    logic [15:0] mem [4096];
    logic [15:0] shadow [4096];

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]  m_acc;
    logic        m_last, m_held, m_owner, m_pv, m_pt;
    logic [15:0] m_pd;

    logic [1:0]  d_rdy, d_rsp;
    logic        d_locked;
    logic [15:0] d_rdata;

    ram_arbiter_if bus ();

    assign bus.reqValid = rv;
    assign bus.reqWrite = rw;
    assign bus.reqLock  = rl;
    assign bus.reqAddr  = {ra[1], ra[0]};
    assign bus.reqWData = {rd[1], rd[0]};

    ram_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] initv(input int a);
        return (a == 16) ? 16'hBEEF : 16'(a * 40503 + 4660);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) mem[i] <= initv(i);
        end else if (bus.ramWriteEnable) begin
            mem[bus.ramWriteAddr[11:0]] <= bus.ramWriteData;
        end
        bus.ramReadData <= mem[bus.ramReadAddr[11:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = 1'b1;
        m_held  = 1'b0;
        m_owner = 1'b0;
        m_pv    = 1'b0;
        m_pt    = 1'b0;
        m_pd    = '0;
        m_acc   = '0;
    endtask

    task automatic cycle();
        logic [1:0]  eg, erv;
        logic        el, w, ewe;
        logic [15:0] erd, ewa, ewd, era;
        @(negedge clk);
        if (m_held)          eg = rv[m_owner] ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        else if (rv == 2'b11) eg = m_last ? 2'b01 : 2'b10;
        else                 eg = rv;
        el  = m_held && rv[m_owner];
        w   = eg[1];
        ewe = (eg != 2'b00) && rw[w];
        ewa = ewe ? ra[w] : 16'h0;
        ewd = ewe ? rd[w] : 16'h0;
        era = ((eg != 2'b00) && !rw[w]) ? ra[w] : 16'h0;
        erv = m_pv ? (m_pt ? 2'b10 : 2'b01) : 2'b00;
        erd = m_pv ? m_pd : 16'h0;
        d_rdy    = bus.reqReady;
        d_rsp    = bus.rspValid;
        d_locked = bus.locked;
        d_rdata  = bus.rspData;
        chk("reqReady", 32'(d_rdy), 32'(eg));
        chk("locked", 32'(d_locked), 32'(el));
        chk("rspValid", 32'(d_rsp), 32'(erv));
        chk("rspData", 32'(d_rdata), 32'(erd));
        chk("ramWE", 32'(bus.ramWriteEnable), 32'(ewe));
        chk("ramWAddr", 32'(bus.ramWriteAddr), 32'(ewa));
        chk("ramWData", 32'(bus.ramWriteData), 32'(ewd));
        chk("ramRAddr", 32'(bus.ramReadAddr), 32'(era));
        @(posedge clk);
        m_acc = eg;
        m_pv  = (eg != 2'b00) && !rw[w];
        m_pt  = w;
        m_pd  = shadow[ra[w][11:0]];
        if (ewe) shadow[ra[w][11:0]] = rd[w];
        if (m_held) begin
            if (!rv[m_owner] || ((eg != 2'b00) && !rl[m_owner])) m_held = 1'b0;
        end else if ((eg != 2'b00) && rl[w]) begin
            m_held  = 1'b1;
            m_owner = w;
        end
        if (eg != 2'b00) m_last = w;
        #1;
    endtask

    initial begin
        int bi, stall, lk;
        rst = 1'b1;
        rv = 2'b11; rw = 2'b00; rl = 2'b00;
        ra[0] = 16'h0; ra[1] = 16'h0; rd[0] = 16'h0; rd[1] = 16'h0;
        for (int i = 0; i < 4096; i++) shadow[i] = initv(i);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_reqReady", 32'(bus.reqReady), 32'h0);
        chk("rst_rspValid", 32'(bus.rspValid), 32'h0);
        chk("rst_rspData", 32'(bus.rspData), 32'h0);
        chk("rst_ramWE", 32'(bus.ramWriteEnable), 32'h0);
        chk("rst_locked", 32'(bus.locked), 32'h0);
        chk("rst_ramRAddr", 32'(bus.ramReadAddr), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // contention from reset: CPU first, then alternating
        ra[0] = 16'h0100; ra[1] = 16'h0200;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("contend_grant", 32'(d_rdy), (k % 2 == 1) ? 32'h2 : 32'h1);
            for (int r = 0; r < 2; r++)
                if (m_acc[r]) ra[r] = 16'($urandom_range(0, 4095));
        end

        rv = 2'b01; rw = 2'b00; ra[0] = 16'h0010;
        cycle();
        chk("cpu_load_ready", 32'(d_rdy), 32'h1);
        rv = 2'b00;
        cycle();
        chk("cpu_load_rspValid", 32'(d_rsp), 32'h1);
        chk("cpu_load_rspData", 32'(d_rdata), 32'hBEEF);

        // debug locked store burst while the CPU waits
        rv = 2'b11; rw = 2'b10; rl = 2'b10; ra[0] = 16'h0040;
        bi = 0; stall = 0; lk = 0;
        for (int k = 0; k < 8 && bi < 4; k++) begin
            ra[1] = 16'(16'h0100 + bi);
            rd[1] = 16'($urandom);
            rl[1] = (bi < 3);
            cycle();
            if (!d_rdy[0]) stall++;
            if (d_locked) lk++;
            if (m_acc[1]) bi++;
        end
        chk("burst_stores", 32'(bi), 32'd4);
        chk("burst_cpu_stall", 32'(stall), 32'd4);
        chk("burst_locked_cycles", 32'(lk), 32'd3);
        rw = 2'b00; rl = 2'b00; ra[1] = 16'h0200;
        cycle();
        chk("burst_cpu_5th", 32'(d_rdy), 32'h1);

        rv = 2'b11; rw = 2'b00; rl = 2'b10; ra[0] = 16'h0041; ra[1] = 16'h0300;
        cycle();
        chk("drop_dbg_grant", 32'(d_rdy), 32'h2);
        rv = 2'b01;
        cycle();
        chk("drop_locked", 32'(d_locked), 32'h0);
        chk("drop_no_grant", 32'(d_rdy), 32'h0);
        cycle();
        chk("drop_cpu_next", 32'(d_rdy), 32'h1);

        rv = 2'b01; rw = 2'b01; rl = 2'b00; ra[0] = 16'h0020; rd[0] = 16'h1234;
        cycle();
        rw = 2'b00;
        cycle();
        rv = 2'b00;
        cycle();
        chk("raw_rspValid", 32'(d_rsp), 32'h1);
        chk("raw_rspData", 32'(d_rdata), 32'h1234);

        for (int k = 0; k < 300; k++) begin
            for (int r = 0; r < 2; r++) begin
                if (rv[r] && m_acc[r]) rv[r] = 1'b0;
                else if (rv[r] && $urandom_range(0, 9) == 0) rv[r] = 1'b0;
                if (!rv[r] && $urandom_range(0, 2) != 0) begin
                    rv[r] = 1'b1;
                    rw[r] = 1'($urandom_range(0, 1));
                    rl[r] = ($urandom_range(0, 4) < 2);
                    ra[r] = 16'($urandom_range(0, 4095));
                    rd[r] = 16'($urandom);
                end
            end
            cycle();
        end

        // reset while a read response is due
        rv = 2'b01; rw = 2'b00; rl = 2'b00; ra[0] = 16'h0033;
        cycle();
        chk("inflight_accept", 32'(d_rdy), 32'h1);
        rst = 1'b1; rv = 2'b00;
        @(negedge clk);
        chk("inflight_rspValid", 32'(bus.rspValid), 32'h0);
        chk("inflight_rspData", 32'(bus.rspData), 32'h0);
        chk("inflight_reqReady", 32'(bus.reqReady), 32'h0);
        chk("inflight_locked", 32'(bus.locked), 32'h0);
        chk("inflight_ramWE", 32'(bus.ramWriteEnable), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        cycle();
        chk("post_rst_rspValid", 32'(d_rsp), 32'h0);
        rv = 2'b11; rw = 2'b00; ra[0] = 16'h0050; ra[1] = 16'h0060;
        cycle();
        chk("post_rst_tie", 32'(d_rdy), 32'h1);
        rv = 2'b00;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
